rasterizer_tri_sequencer: RTL and testbench

Sits between the triangle setup stage and the rasterizer backend, and sequences one triangle at a time through it. It accepts a triangle descriptor over a valid/ready handshake and holds the descriptor stable on the backend inputs. It then restarts the backend and forwards the backend's qualified pixel stream, with the triangle's colour attached, to the framebuffer/z-test stage. It also culls degenerate bounding boxes, counts triangles, flags frame completion and aborts hung rasterizations with a watchdog.

---
 rtl/rasterizer_tri_sequencer.sv | 167 ++++++++++++++++
 tb/tb_rasterizer_tri_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rasterizer_tri_sequencer.sv
// rtl/rasterizer_tri_sequencer.sv - one-triangle-at-a-time sequencer between setup and rasterizer backend
module rasterizer_tri_sequencer #(
  parameter int DATA_WIDTH        = 16,
  parameter int DEPTH_WIDTH       = 16,
  parameter int BUFFER_ADDR_WIDTH = 15,
  parameter int COLOR_WIDTH       = 12,
  parameter int WDOG_CYCLES       = 32768
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                tri_valid,
  output logic                                tri_ready,
  input  logic                                tri_last,
  input  logic signed [1:0][DATA_WIDTH-1:0]   tri_bb_tl,
  input  logic signed [1:0][DATA_WIDTH-1:0]   tri_bb_br,
  input  logic signed [DATA_WIDTH-1:0]        tri_edge0,
  input  logic signed [DATA_WIDTH-1:0]        tri_edge1,
  input  logic signed [DATA_WIDTH-1:0]        tri_edge2,
  input  logic signed [1:0][DATA_WIDTH-1:0]   tri_edge_delta0,
  input  logic signed [1:0][DATA_WIDTH-1:0]   tri_edge_delta1,
  input  logic signed [1:0][DATA_WIDTH-1:0]   tri_edge_delta2,
  input  logic signed [DATA_WIDTH-1:0]        tri_z,
  input  logic signed [1:0][DATA_WIDTH-1:0]   tri_z_delta,
  input  logic [BUFFER_ADDR_WIDTH-1:0]        tri_addr_start,
  input  logic [COLOR_WIDTH-1:0]              tri_color,
  output logic signed [1:0][DATA_WIDTH-1:0]   be_bb_tl,
  output logic signed [1:0][DATA_WIDTH-1:0]   be_bb_br,
  output logic signed [DATA_WIDTH-1:0]        be_edge0,
  output logic signed [DATA_WIDTH-1:0]        be_edge1,
  output logic signed [DATA_WIDTH-1:0]        be_edge2,
  output logic signed [1:0][DATA_WIDTH-1:0]   be_edge_delta0,
  output logic signed [1:0][DATA_WIDTH-1:0]   be_edge_delta1,
  output logic signed [1:0][DATA_WIDTH-1:0]   be_edge_delta2,
  output logic signed [DATA_WIDTH-1:0]        be_z,
  output logic signed [1:0][DATA_WIDTH-1:0]   be_z_delta,
  output logic [BUFFER_ADDR_WIDTH-1:0]        be_buffer_addr_start,
  output logic                                be_start,
  input  logic                                be_done,
  input  logic                                be_inside,
  input  logic [BUFFER_ADDR_WIDTH-1:0]        be_addr,
  input  logic signed [DEPTH_WIDTH-1:0]       be_depth,
  output logic                                pix_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0]        pix_addr,
  output logic signed [DEPTH_WIDTH-1:0]       pix_depth,
  output logic [COLOR_WIDTH-1:0]              pix_color,
  output logic                                busy,
  output logic                                frame_done,
  output logic [15:0]                         tri_count,
  output logic [15:0]                         cull_count,
  output logic                                wdog_err
);

  localparam int WCW = $clog2(WDOG_CYCLES);

  typedef enum logic [2:0] {IDLE, LAUNCH, SETUP, RUN, FINISH} state_e;

  state_e                          state_q, state_d;
  logic [WCW-1:0]                  wdog_q;
  logic [COLOR_WIDTH-1:0]          color_q;
  logic                            last_q;
  logic                            pix_valid_q;
  logic [BUFFER_ADDR_WIDTH-1:0]    pix_addr_q;
  logic signed [DEPTH_WIDTH-1:0]   pix_depth_q;
  logic [COLOR_WIDTH-1:0]          pix_color_q;
  logic                            frame_done_q;
  logic [15:0]                     tri_count_q, cull_count_q;
  logic                            wdog_err_q;

  logic accept, degen, wdog_hit, fwd, tri_inc, cull_inc;

  assign tri_ready = rstn && (state_q == IDLE);
  assign accept    = tri_valid && tri_ready;
  assign degen     = ($signed(tri_bb_br[0]) < $signed(tri_bb_tl[0])) ||
                     ($signed(tri_bb_br[1]) < $signed(tri_bb_tl[1]));
  assign wdog_hit  = (wdog_q == WCW'(WDOG_CYCLES - 1));
  assign fwd       = (state_q == RUN) && !be_done && be_inside;
  assign tri_inc   = (state_q == FINISH) || (accept && degen);
  assign cull_inc  = accept && degen;

  // Counters clear in the cycle after frame_done, but a triangle finishing in that same cycle still counts.
  function automatic logic [15:0] bump(input logic [15:0] v, input logic en, input logic clr);
    logic [15:0] base;
    base = clr ? 16'd0 : v;
    return (en && base != 16'hFFFF) ? base + 16'd1 : base;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !degen) state_d = LAUNCH;
      LAUNCH:  state_d = SETUP;
      SETUP:   state_d = RUN;
      RUN:     if (be_done || wdog_hit) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q              <= IDLE;
      wdog_q               <= '0;
      color_q              <= '0;
      last_q               <= 1'b0;
      be_bb_tl             <= '0;
      be_bb_br             <= '0;
      be_edge0             <= '0;
      be_edge1             <= '0;
      be_edge2             <= '0;
      be_edge_delta0       <= '0;
      be_edge_delta1       <= '0;
      be_edge_delta2       <= '0;
      be_z                 <= '0;
      be_z_delta           <= '0;
      be_buffer_addr_start <= '0;
      pix_valid_q          <= 1'b0;
      pix_addr_q           <= '0;
      pix_depth_q          <= '0;
      pix_color_q          <= '0;
      frame_done_q         <= 1'b0;
      tri_count_q          <= '0;
      cull_count_q         <= '0;
      wdog_err_q           <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        be_bb_tl             <= tri_bb_tl;
        be_bb_br             <= tri_bb_br;
        be_edge0             <= tri_edge0;
        be_edge1             <= tri_edge1;
        be_edge2             <= tri_edge2;
        be_edge_delta0       <= tri_edge_delta0;
        be_edge_delta1       <= tri_edge_delta1;
        be_edge_delta2       <= tri_edge_delta2;
        be_z                 <= tri_z;
        be_z_delta           <= tri_z_delta;
        be_buffer_addr_start <= tri_addr_start;
        color_q              <= tri_color;
        last_q               <= tri_last;
      end
      if (state_q == LAUNCH) wdog_q <= '0;
      else if (state_q == RUN) wdog_q <= wdog_q + 1'b1;
      if (state_q == RUN && !be_done && wdog_hit) wdog_err_q <= 1'b1;
      pix_valid_q <= fwd;
      if (fwd) begin
        pix_addr_q  <= be_addr;
        pix_depth_q <= be_depth;
        pix_color_q <= color_q;
      end
      frame_done_q <= ((state_q == FINISH) && last_q) || (accept && degen && tri_last);
      tri_count_q  <= bump(tri_count_q, tri_inc, frame_done_q);
      cull_count_q <= bump(cull_count_q, cull_inc, frame_done_q);
    end
  end

  assign be_start   = (state_q == LAUNCH);
  assign busy       = (state_q == LAUNCH) || (state_q == SETUP) || (state_q == RUN);
  assign pix_valid  = pix_valid_q;
  assign pix_addr   = pix_addr_q;
  assign pix_depth  = pix_depth_q;
  assign pix_color  = pix_color_q;
  assign frame_done = frame_done_q;
  assign tri_count  = tri_count_q;
  assign cull_count = cull_count_q;
  assign wdog_err   = wdog_err_q;

endmodule

// File: tb/tb_rasterizer_tri_sequencer.sv
// tb/tb_rasterizer_tri_sequencer.sv - table-driven bench with backend model and pixel scoreboard
module tb_rasterizer_tri_sequencer;
  localparam int DW = 16, AW = 15, CW = 12, FBW = 160;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic tri_valid, tri_ready, tri_last;
  logic signed [1:0][DW-1:0] tri_bb_tl, tri_bb_br, tri_edge_delta0, tri_edge_delta1, tri_edge_delta2, tri_z_delta;
  logic signed [DW-1:0] tri_edge0, tri_edge1, tri_edge2, tri_z;
  logic [AW-1:0] tri_addr_start;
  logic [CW-1:0] tri_color;
  logic signed [1:0][DW-1:0] be_bb_tl, be_bb_br, be_edge_delta0, be_edge_delta1, be_edge_delta2, be_z_delta;
  logic signed [DW-1:0] be_edge0, be_edge1, be_edge2, be_z;
  logic [AW-1:0] be_buffer_addr_start, be_addr, pix_addr;
  logic be_start, be_done, be_inside, pix_valid, busy, frame_done, wdog_err;
  logic signed [DW-1:0] be_depth, pix_depth;
  logic [CW-1:0] pix_color;
  logic [15:0] tri_count, cull_count;

  rasterizer_tri_sequencer #(.WDOG_CYCLES(64)) dut (
    .clk(clk), .rstn(rstn), .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_last(tri_last),
    .tri_bb_tl(tri_bb_tl), .tri_bb_br(tri_bb_br), .tri_edge0(tri_edge0), .tri_edge1(tri_edge1),
    .tri_edge2(tri_edge2), .tri_edge_delta0(tri_edge_delta0), .tri_edge_delta1(tri_edge_delta1),
    .tri_edge_delta2(tri_edge_delta2), .tri_z(tri_z), .tri_z_delta(tri_z_delta),
    .tri_addr_start(tri_addr_start), .tri_color(tri_color),
    .be_bb_tl(be_bb_tl), .be_bb_br(be_bb_br), .be_edge0(be_edge0), .be_edge1(be_edge1),
    .be_edge2(be_edge2), .be_edge_delta0(be_edge_delta0), .be_edge_delta1(be_edge_delta1),
    .be_edge_delta2(be_edge_delta2), .be_z(be_z), .be_z_delta(be_z_delta),
    .be_buffer_addr_start(be_buffer_addr_start), .be_start(be_start), .be_done(be_done),
    .be_inside(be_inside), .be_addr(be_addr), .be_depth(be_depth),
    .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_depth(pix_depth), .pix_color(pix_color),
    .busy(busy), .frame_done(frame_done), .tri_count(tri_count), .cull_count(cull_count),
    .wdog_err(wdog_err)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Backend model: scans the bbox row-major, one pixel per cycle after a one-cycle setup.
  logic hang = 1'b0;
  logic phase, bdone;
  int bx, by, dxm, dym;
  wire be_rstn = rstn & ~be_start;

  function automatic int ev(input int e, input int sx, input int sy, input int dx, input int dy);
    return e + dx * sx + dy * sy;
  endfunction

  always @(posedge clk) begin
    if (!be_rstn) begin
      bx <= int'($signed(be_bb_tl[0])); by <= int'($signed(be_bb_tl[1]));
      phase <= 1'b0; bdone <= 1'b0;
    end else if (!phase) begin
      phase <= 1'b1;
    end else if (!bdone && !hang) begin
      if (bx == int'($signed(be_bb_br[0]))) begin
        if (by == int'($signed(be_bb_br[1]))) bdone <= 1'b1;
        else begin bx <= int'($signed(be_bb_tl[0])); by <= by + 1; end
      end else bx <= bx + 1;
    end
  end

  assign dxm = bx - int'($signed(be_bb_tl[0]));
  assign dym = by - int'($signed(be_bb_tl[1]));
  assign be_done = bdone;
  assign be_inside = phase && !bdone && !hang &&
      ev(int'(be_edge0), int'($signed(be_edge_delta0[0])), int'($signed(be_edge_delta0[1])), dxm, dym) >= 0 &&
      ev(int'(be_edge1), int'($signed(be_edge_delta1[0])), int'($signed(be_edge_delta1[1])), dxm, dym) >= 0 &&
      ev(int'(be_edge2), int'($signed(be_edge_delta2[0])), int'($signed(be_edge_delta2[1])), dxm, dym) >= 0;
  assign be_addr  = AW'(int'(be_buffer_addr_start) + dym * FBW + dxm);
  assign be_depth = DW'(ev(int'(be_z), int'($signed(be_z_delta[0])), int'($signed(be_z_delta[1])), dxm, dym));

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; logic [CW-1:0] c; } pix_t;
  pix_t sb[$];

  int pix_seen = 0, starts = 0, fds = 0, busy_cycles = 0, fd_tri = -1, fd_cull = -1;

  always @(negedge clk) begin
    if (pix_valid) begin
      pix_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected: got addr %0d, required no pixel", pix_addr);
      end else begin
        pix_t e;
        e = sb.pop_front();
        if ({pix_addr, pix_depth, pix_color} !== e) begin
          errors++;
          $display("FAIL pix: got a=%0d d=%0d c=%h expected a=%0d d=%0d c=%h",
                   pix_addr, pix_depth, pix_color, e.a, $signed(e.d), e.c);
        end
      end
    end
    if (be_start) starts++;
    if (busy) busy_cycles++;
    if (frame_done) begin fds++; fd_tri = tri_count; fd_cull = cull_count; end
    checks++;
    if (tri_ready && busy) begin errors++; $display("FAIL ready_while_busy: got 1 required 0"); end
  end

  typedef struct {
    int tlx, tly, brx, bry, e0, ex0, z, zx, zy, addr, color;
    bit last;
    int exp_pix, exp_start, exp_fd, exp_tri, exp_cull;
  } vec_t;

  function automatic vec_t mk(input int tlx, tly, brx, bry, addr, color, input bit last,
                              input int exp_pix, exp_start, exp_fd, exp_tri, exp_cull);
    vec_t v;
    v.tlx = tlx; v.tly = tly; v.brx = brx; v.bry = bry; v.e0 = 1; v.ex0 = 0;
    v.z = 0; v.zx = 0; v.zy = 0; v.addr = addr; v.color = color; v.last = last;
    v.exp_pix = exp_pix; v.exp_start = exp_start; v.exp_fd = exp_fd;
    v.exp_tri = exp_tri; v.exp_cull = exp_cull;
    return v;
  endfunction

  task automatic push_expected(input vec_t v);
    for (int dy = 0; dy <= v.bry - v.tly; dy++)
      for (int dx = 0; dx <= v.brx - v.tlx; dx++)
        if (v.e0 + dx * v.ex0 >= 0) begin
          pix_t p;
          p.a = AW'(v.addr + dy * FBW + dx);
          p.d = DW'(v.z + dx * v.zx + dy * v.zy);
          p.c = CW'(v.color);
          sb.push_back(p);
        end
  endtask

  task automatic send(input vec_t v, input bit expect_pix);
    int n = 0;
    tri_bb_tl[0] = DW'(v.tlx); tri_bb_tl[1] = DW'(v.tly);
    tri_bb_br[0] = DW'(v.brx); tri_bb_br[1] = DW'(v.bry);
    tri_edge0 = DW'(v.e0); tri_edge1 = 16'sd1; tri_edge2 = 16'sd1;
    tri_edge_delta0[0] = DW'(v.ex0); tri_edge_delta0[1] = '0;
    tri_edge_delta1 = '0; tri_edge_delta2 = '0;
    tri_z = DW'(v.z); tri_z_delta[0] = DW'(v.zx); tri_z_delta[1] = DW'(v.zy);
    tri_addr_start = AW'(v.addr); tri_color = CW'(v.color); tri_last = v.last;
    tri_valid = 1'b1;
    while (!tri_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (n >= 500) begin checks++; errors++; $display("FAIL accept_timeout: got no tri_ready required 1"); end
    if (expect_pix && v.brx >= v.tlx && v.bry >= v.tly) push_expected(v);
    @(posedge clk); #1;
    tri_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!tri_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (n >= 500) begin checks++; errors++; $display("FAIL idle_timeout: got busy required idle"); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tri_ready"}, tri_ready, 0);
    chk({tag, "_be_start"}, be_start, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_tri_count"}, tri_count, 0);
    chk({tag, "_cull_count"}, cull_count, 0);
    chk({tag, "_wdog_err"}, wdog_err, 0);
    chk({tag, "_be_regs"}, int'({be_bb_tl, be_bb_br, be_z} != '0) + int'(be_buffer_addr_start), 0);
    chk({tag, "_pix_regs"}, int'(pix_addr) + int'(pix_depth != '0) + int'(pix_color), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    vec_t v;
    int s0, p0, f0, b0;

    tbl[0] = mk(5, 0, 2, 3, 0, 12'h111, 1'b1, 0, 0, 1, 1, 1);      // x-degenerate, last
    tbl[1] = mk(0, 0, 3, 3, 0, 12'hA5C, 1'b0, 16, 1, 0, 1, 0);     // 4x4 all inside
    tbl[2] = mk(0, 0, 3, 1, 1000, 12'h3F0, 1'b0, 4, 1, 0, 2, 0);   // 4x2 mixed edges
    tbl[2].e0 = -2; tbl[2].ex0 = 1; tbl[2].z = 100; tbl[2].zx = 3; tbl[2].zy = -7;
    tbl[3] = mk(0, 4, 0, -1, 0, 12'h222, 1'b0, 0, 0, 0, 3, 1);     // y-degenerate (signed)
    tbl[4] = mk(7, 7, 7, 7, 7000, 12'hFFF, 1'b1, 1, 1, 1, 4, 1);   // 1x1, last

    tri_valid = 1'b0; tri_last = 1'b0;
    tri_bb_tl = '0; tri_bb_br = '0; tri_edge0 = '0; tri_edge1 = '0; tri_edge2 = '0;
    tri_edge_delta0 = '0; tri_edge_delta1 = '0; tri_edge_delta2 = '0;
    tri_z = '0; tri_z_delta = '0; tri_addr_start = '0; tri_color = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("init");
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", tri_ready, 1);

    for (int i = 0; i < 5; i++) begin
      s0 = starts; p0 = pix_seen; f0 = fds;
      send(tbl[i], 1'b1);
      wait_idle();
      chk($sformatf("v%0d_pixels", i), pix_seen - p0, tbl[i].exp_pix);
      chk($sformatf("v%0d_starts", i), starts - s0, tbl[i].exp_start);
      chk($sformatf("v%0d_frame_done", i), fds - f0, tbl[i].exp_fd);
      chk($sformatf("v%0d_sb_left", i), sb.size(), 0);
      if (tbl[i].exp_fd != 0) begin
        chk($sformatf("v%0d_fd_tri", i), fd_tri, tbl[i].exp_tri);
        chk($sformatf("v%0d_fd_cull", i), fd_cull, tbl[i].exp_cull);
        chk($sformatf("v%0d_tri_clr", i), tri_count, 0);
        chk($sformatf("v%0d_cull_clr", i), cull_count, 0);
      end else begin
        chk($sformatf("v%0d_tri_count", i), tri_count, tbl[i].exp_tri);
        chk($sformatf("v%0d_cull_count", i), cull_count, tbl[i].exp_cull);
      end
    end

    // Back-to-back descriptors with tri_valid held high, last on the third.
    s0 = starts; p0 = pix_seen; f0 = fds;
    for (int k = 0; k < 3; k++) begin
      v = mk(0, 0, 1, 1, 200 * k, 12'h100 + k, k == 2, 0, 0, 0, 0, 0);
      send(v, 1'b1);
    end
    wait_idle();
    chk("b2b_starts", starts - s0, 3);
    chk("b2b_pixels", pix_seen - p0, 12);
    chk("b2b_frame_done", fds - f0, 1);
    chk("b2b_fd_tri", fd_tri, 3);
    chk("b2b_tri_clr", tri_count, 0);

    // Watchdog: backend never finishes.
    hang = 1'b1; b0 = busy_cycles; p0 = pix_seen;
    v = mk(0, 0, 3, 3, 0, 12'h0AA, 1'b0, 0, 0, 0, 0, 0);
    send(v, 1'b0);
    wait_idle();
    chk("wdog_busy_cycles", busy_cycles - b0, 66);
    chk("wdog_err_set", wdog_err, 1);
    chk("wdog_ready", tri_ready, 1);
    chk("wdog_pixels", pix_seen - p0, 0);
    chk("wdog_tri_count", tri_count, 1);
    hang = 1'b0; p0 = pix_seen;
    v = mk(2, 3, 3, 4, 50, 12'h0BB, 1'b0, 0, 0, 0, 0, 0);
    v.z = -5; v.zx = 2; v.zy = 1;
    send(v, 1'b1);
    wait_idle();
    chk("post_wdog_pixels", pix_seen - p0, 4);
    chk("wdog_err_sticky", wdog_err, 1);
    chk("post_wdog_tri", tri_count, 2);

    // Reset asserted mid-RUN of a 10x10 triangle.
    v = mk(0, 0, 9, 9, 0, 12'h777, 1'b0, 0, 0, 0, 0, 0);
    send(v, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("mid_run_busy", busy, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_reset("midrst");
    sb.delete();
    p0 = pix_seen;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no_pix_after_reset", pix_seen - p0, 0);
    v = mk(1, 1, 2, 2, 500, 12'hC3C, 1'b0, 0, 0, 0, 0, 0);
    send(v, 1'b1);
    wait_idle();
    chk("post_reset_pixels", pix_seen - p0, 4);
    chk("post_reset_tri", tri_count, 1);
    chk("post_reset_sb", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
